multiplicador_secuencial: RTL and testbench

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

---
 rtl/multiplicador_secuencial.sv | 138 +++++++++++++
 tb/tb_multiplicador_secuencial.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-and-add multiplier: sign-magnitude operands, N-bit datapath,
// 2N-bit product split into out/prod_hi with optional saturation of out.
//   state | meaning
//   IDLE  | ready for operands
//   CALC  | one multiplier bit per edge, plus a terminal-count edge
//   FIX   | reapply sign, compute overflow, register results
//   DONE  | results held until out_ready
module multiplicador_secuencial #(
    parameter int N      = 24,
    parameter bit SAT_EN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [N-1:0] prod_hi,
    output logic         overflow,
    output logic         car
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic           smode;

    logic           accept;
    logic           cnt_tc;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [2*N-1:0] prod;
    logic           ovf_calc;
    logic [N-1:0]   sat_val;
    logic [N-1:0]   out_calc;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign cnt_tc   = (cnt == '0);
    assign car      = 1'b0;

    // Magnitudes stay N bits unsigned, so -2^(N-1) maps to 2^(N-1) correctly.
    always_comb begin
        mag_a = A;
        mag_b = B;
        if (signed_mode && A[N-1]) mag_a = -A;
        if (signed_mode && B[N-1]) mag_b = -B;
    end

    always_comb begin
        prod     = neg ? -acc : acc;
        ovf_calc = 1'b0;
        sat_val  = '1;
        if (smode) begin
            ovf_calc = (prod[2*N-1:N-1] != {(N+1){prod[N-1]}});
            sat_val  = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            ovf_calc = (prod[2*N-1:N] != '0);
        end
        out_calc = (SAT_EN && ovf_calc) ? sat_val : prod[N-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = CALC;
            CALC: if (cnt_tc)    state_next = FIX;
            FIX:                 state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            smode     <= 1'b0;
            out       <= '0;
            prod_hi   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        mcand  <= {{N{1'b0}}, mag_a};
                        mplier <= mag_b;
                        cnt    <= CW'(N);
                        neg    <= signed_mode && (A[N-1] ^ B[N-1]);
                        smode  <= signed_mode;
                    end
                end
                CALC: begin
                    // The terminal-count edge does no arithmetic; it keeps latency fixed.
                    if (!cnt_tc) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    out       <= out_calc;
                    prod_hi   <= prod[2*N-1:N];
                    overflow  <= ovf_calc;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial at N=8: wrap and saturating instances in
// lockstep, checked against an integer-arithmetic reference model.
module tb_multiplicador_secuencial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       smode;
    logic       out_ready;

    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out0, out1, hi0, hi1;
    logic       ovf0, ovf1, car0, car1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiplicador_secuencial #(.N(8), .SAT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .A(a_in), .B(b_in), .signed_mode(smode), .out_valid(out_valid0),
        .out_ready(out_ready), .out(out0), .prod_hi(hi0), .overflow(ovf0), .car(car0)
    );

    multiplicador_secuencial #(.N(8), .SAT_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .A(a_in), .B(b_in), .signed_mode(smode), .out_valid(out_valid1),
        .out_ready(out_ready), .out(out1), .prod_hi(hi1), .overflow(ovf1), .car(car1)
    );

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic sm,
                                  output logic [7:0] lo, output logic [7:0] hi,
                                  output logic [7:0] sat_lo, output logic ovf);
        int va, vb, p;
        logic [15:0] p16;
        va = sm ? int'($signed(a)) : int'(a);
        vb = sm ? int'($signed(b)) : int'(b);
        p = va * vb;
        p16 = p[15:0];
        lo = p16[7:0];
        hi = p16[15:8];
        ovf = sm ? (p < -128 || p > 127) : (p > 255);
        if (!ovf)    sat_lo = lo;
        else if (sm) sat_lo = (p < 0) ? 8'h80 : 8'h7F;
        else         sat_lo = 8'hFF;
    endfunction

    // Called between edges; returns one time unit after the edge where out_valid rose
    // (lat = edges after the accept edge, -1 if it never rose).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm, output int lat);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        smode = sm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        smode = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_in = '0;
        b_in = '0;
        smode = 1'b0;
        #1;
        total++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || out0 !== 8'h00 || hi0 !== 8'h00 ||
            ovf0 !== 1'b0 || car0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b out=%h hi=%h ovf=%b car=%b, want 1 0 00 00 0 0",
                     in_ready0, out_valid0, out0, hi0, ovf0, car0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_first_accept();
        int lat;
        @(negedge clk);
        run_op(8'hFD, 8'h05, 1'b1, lat);
        total++;
        if (lat != 10 || out0 !== 8'hF1 || hi0 !== 8'hFF || ovf0 !== 1'b0 || out1 !== 8'hF1) begin
            bad++;
            $display("FAIL first_accept_m3x5: lat=%0d out=%h hi=%h ovf=%b sat_out=%h, want 10 F1 FF 0 F1",
                     lat, out0, hi0, ovf0, out1);
        end
        release_op();
    endtask

    task automatic test_directed();
        logic [7:0] va[6]   = '{8'h10, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h00};
        logic [7:0] vb[6]   = '{8'h10, 8'h80, 8'h01, 8'hFF, 8'hC8, 8'hFB};
        logic       vs[6]   = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        logic [7:0] eout[6] = '{8'h00, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00};
        logic [7:0] ehi[6]  = '{8'h01, 8'h40, 8'hFF, 8'hFE, 8'h00, 8'h00};
        logic       eovf[6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        logic [7:0] esat[6] = '{8'h7F, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h00};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], lat);
            total++;
            if (lat != 10 || out0 !== eout[i] || hi0 !== ehi[i] || ovf0 !== eovf[i] ||
                out1 !== esat[i] || hi1 !== ehi[i] || ovf1 !== eovf[i]) begin
                bad++;
                $display("FAIL directed_%0d: lat=%0d out=%h hi=%h ovf=%b sat_out=%h, want 10 %h %h %b %h",
                         i, lat, out0, hi0, ovf0, out1, eout[i], ehi[i], eovf[i], esat[i]);
            end
            release_op();
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, lo, hi, slo;
        logic sm, ovf;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sm = 1'($urandom);
            if (i % 8 == 0) a = 8'h80;
            model(a, b, sm, lo, hi, slo, ovf);
            run_op(a, b, sm, lat);
            total++;
            if (lat != 10 || out0 !== lo || hi0 !== hi || ovf0 !== ovf || out1 !== slo ||
                hi1 !== hi || car0 !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h s=%b: lat=%0d out=%h hi=%h ovf=%b sat=%h, want 10 %h %h %b %h",
                         i, a, b, sm, lat, out0, hi0, ovf0, out1, lo, hi, ovf, slo);
            end
            release_op();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lo, hi, slo;
        logic ovf;
        int lat;
        model(8'h5A, 8'h33, 1'b0, lo, hi, slo, ovf);
        run_op(8'h5A, 8'h33, 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            total++;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out0 !== lo || hi0 !== hi || ovf0 !== ovf) begin
                bad++;
                $display("FAIL backpressure_%0d: vld=%b rdy=%b out=%h hi=%h ovf=%b, want 1 0 %h %h %b",
                         c, out_valid0, in_ready0, out0, hi0, ovf0, lo, hi, ovf);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: rdy=%b vld=%b, want 1 0", in_ready0, out_valid0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        in_valid = 1'b1;
        a_in = 8'h64;
        b_in = 8'h03;
        smode = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || in_ready1 !== 1'b1 || out0 !== 8'h00 || hi0 !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_calc: vld=%b rdy=%b out=%h hi=%h, want 0 1 00 00",
                     out_valid0, in_ready0, out0, hi0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h07, 8'h09, 1'b1, lat);
        total++;
        if (lat != 10 || out0 !== 8'h3F || hi0 !== 8'h00 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_then_7x9: lat=%0d out=%h hi=%h ovf=%b, want 10 3F 00 0",
                     lat, out0, hi0, ovf0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || in_ready0 !== 1'b1 || out0 !== 8'h00) begin
            bad++;
            $display("FAIL reset_in_done: vld=%b/%b rdy=%b out=%h, want 0/0 1 00",
                     out_valid0, out_valid1, in_ready0, out0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
